// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction fetch path: address/word widths,
// reset vector, fetch control state encoding and a PC increment helper.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_W  = 16;
    localparam int INS_W = 16;

    localparam logic [PC_W-1:0] RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // Sequential fetch address; wraps 16'hFFFF -> 16'h0000 naturally.
    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry synchronous FIFO holding {pc, word} pairs between the fetch
// stage and decode. The head is presented combinationally from registered
// storage and reads as zero while the queue is empty.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        drop all entries (wins over push/pop)
//   push         write {push_pc, push_data} at the tail
//   pop          retire the head entry
//   push_pc      PC of the word being written
//   push_data    word being written
//   head_valid   queue not empty
//   head_pc      PC of the head entry (0 when empty)
//   head_data    word at the head (0 when empty)
//   count        number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int WIDTH = INS_W,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [PC_W-1:0]          push_pc,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     head_valid,
    output logic [PC_W-1:0]          head_pc,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop & ~flush & ~empty;
    // A push into a full queue is only legal when the head leaves this cycle.
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]   <= push_pc;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_valid = ~empty;
    assign head_pc    = empty ? '0 : pc_mem[rd_ptr];
    assign head_data  = empty ? '0 : data_mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch controller for a zero-latency combinational ROM. Owns the
// program counter, fetches one word per cycle into fetch_queue and hands words
// to decode over a valid/ready handshake. Supports branch redirect (flushes the
// queue, highest priority) and a halt level that freezes fetching while the
// queue keeps draining.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_add        ROM address (the pc register)
//   imem_data       ROM word for imem_add, same cycle
//   redirect_valid  one-cycle request to load redirect_pc
//   redirect_pc     redirect target
//   halt            level; no fetches while high
//   ins_valid       head of queue valid
//   ins_ready       decode accepts the head
//   ins_data        head word (0 when empty)
//   ins_pc          PC of head word (0 when empty)
//   q_count         occupied queue entries
//
// Control state (observability only; datapath follows push/pop rules):
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_RUN   | fetching normally
//   ST_STALL | queue full and head not taken, pc held
//   ST_HOLD  | halt asserted, no fetches
// -----------------------------------------------------------------------------
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              WIDTH    = INS_W,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = RESET_VECTOR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [PC_W-1:0]          imem_add,
    input  logic [WIDTH-1:0]         imem_data,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     halt,
    output logic                     ins_valid,
    input  logic                     ins_ready,
    output logic [WIDTH-1:0]         ins_data,
    output logic [PC_W-1:0]          ins_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PC_W-1:0] pc;
    fetch_state_e    state;

    logic            pop;
    logic            q_pop;
    logic            push;
    logic            full;
    logic            stall_cond;

    assign imem_add = pc;

    assign full  = (q_count == FULL_COUNT);
    assign pop   = ins_valid & ins_ready;
    // Redirect flushes rather than retires, so the head is not consumed.
    assign q_pop = pop & ~redirect_valid;
    assign push  = ~redirect_valid & ~halt & (~full | pop);

    assign stall_cond = full & ~pop & ~redirect_valid;

    fetch_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (q_pop),
        .push_pc    (pc),
        .push_data  (imem_data),
        .head_valid (ins_valid),
        .head_pc    (ins_pc),
        .head_data  (ins_data),
        .count      (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc_incr(pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt) begin
                        state <= ST_HOLD;
                    end else if (stall_cond) begin
                        state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (halt) begin
                        state <= ST_HOLD;
                    end else if (!stall_cond) begin
                        state <= ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (!halt) begin
                        state <= stall_cond ? ST_STALL : ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
